// File: rtl/tensor_stream_pkg.sv
// rtl/tensor_stream_pkg.sv - shared sizing helpers and loader state type
package tensor_stream_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } load_state_e;

  function automatic int num_elems(input int b, input int c, input int h, input int w);
    return b * c * h * w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tensor_bank.sv
// rtl/tensor_bank.sv - N-element register bank with indexed element write
module tensor_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 128,
  parameter int CW         = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [CW-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [N*DATA_WIDTH-1:0] data
);

  // Elements not addressed keep their old value, so a partial tensor
  // leaves the tail of the previous one in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (we) begin
      for (int i = 0; i < N; i++) begin
        if (waddr == CW'(i)) begin
          data[i*DATA_WIDTH +: DATA_WIDTH] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/tensor_stream_loader.sv
// rtl/tensor_stream_loader.sv - element stream to flat tensor bus; TENSOR_LOADER_PINGPONG_EN selects two banks
module tensor_stream_loader
  import tensor_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BATCH_SIZE = 1,
  parameter int CHANNELS   = 32,
  parameter int HEIGHT     = 4,
  parameter int WIDTH      = 4,
  localparam int N  = num_elems(BATCH_SIZE, CHANNELS, HEIGHT, WIDTH),
  localparam int CW = cnt_width(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  output logic [N*DATA_WIDTH-1:0] tensor_out,
  output logic                    tensor_valid,
  input  logic                    tensor_ack,
  output logic                    frame_err
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d;
  logic          tensor_valid_q, tensor_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          accept, at_last, done, ack_eff;

  assign accept  = s_valid && s_ready_q;
  assign at_last = (cnt_q == LAST_IDX);
  assign done    = accept && at_last;
  assign ack_eff = tensor_ack && tensor_valid_q;

  assign s_ready      = s_ready_q;
  assign tensor_valid = tensor_valid_q;
  assign frame_err    = frame_err_q;

  // An early s_last abandons the partial tensor; a missing one on the final
  // beat is flagged but the tensor still completes.
  always_comb begin
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    if (accept) begin
      cnt_d       = (at_last || s_last) ? '0 : cnt_q + CW'(1);
      frame_err_d = at_last ? !s_last : s_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      s_ready_q      <= 1'b0;
      tensor_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      s_ready_q      <= s_ready_d;
      tensor_valid_q <= tensor_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

`ifdef TENSOR_LOADER_PINGPONG_EN

  // full_q marks banks holding a complete tensor; banks complete and present
  // in strict alternation, so pres_q only ever advances on an ack.
  logic                    fill_q, fill_d;
  logic                    pres_q, pres_d;
  logic [1:0]              full_q, full_d;
  logic [N*DATA_WIDTH-1:0] bank0_data, bank1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= 1'b0;
      pres_q <= 1'b0;
      full_q <= 2'b00;
    end else begin
      fill_q <= fill_d;
      pres_q <= pres_d;
      full_q <= full_d;
    end
  end

  always_comb begin
    full_d = full_q;
    if (ack_eff) full_d[pres_q] = 1'b0;
    if (done) full_d[fill_q] = 1'b1;
    fill_d = fill_q ^ done;
    pres_d = pres_q ^ ack_eff;
  end

  always_comb begin
    s_ready_d      = ~&full_d;
    tensor_valid_d = full_d[pres_d];
  end

  tensor_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .CW(CW)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !fill_q),
    .waddr (cnt_q),
    .wdata (s_data),
    .data  (bank0_data)
  );

  tensor_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .CW(CW)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && fill_q),
    .waddr (cnt_q),
    .wdata (s_data),
    .data  (bank1_data)
  );

  assign tensor_out = pres_q ? bank1_data : bank0_data;

`else

  load_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (done) state_d = HOLD;
      HOLD:    if (ack_eff) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs are registered from the next state so they change with it.
  always_comb begin
    s_ready_d      = (state_d == FILL);
    tensor_valid_d = (state_d == HOLD);
  end

  tensor_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .CW(CW)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (cnt_q),
    .wdata (s_data),
    .data  (tensor_out)
  );

`endif

endmodule

// File: tb/tb_tensor_stream_loader.sv
// tb/tb_tensor_stream_loader.sv - vector table, corner sequences and random run against a queue model
module tb_tensor_stream_loader;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int TW = N * DW;
`ifdef TENSOR_LOADER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic [TW-1:0] tensor_out;
  logic          tensor_valid;
  logic          tensor_ack = 1'b0;
  logic          frame_err;

  tensor_stream_loader #(
    .DATA_WIDTH(DW), .BATCH_SIZE(1), .CHANNELS(2), .HEIGHT(2), .WIDTH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .tensor_out   (tensor_out),
    .tensor_valid (tensor_valid),
    .tensor_ack   (tensor_ack),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: banks of elements, a partial-tensor queue and a queue of completed
  // banks awaiting presentation (capacity NB).
  logic [DW-1:0] m_mem [2][N];
  logic [DW-1:0] m_cur [$];
  int            m_done_q [$];
  int            m_fill;
  bit            m_ready, m_valid, m_ferr;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) for (int k = 0; k < N; k++) m_mem[b][k] = '0;
    m_cur.delete();
    m_done_q.delete();
    m_fill  = 0;
    m_ready = 0;
    m_valid = 0;
    m_ferr  = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [DW-1:0] d, input bit l, input bit a);
    bit acc = v && m_ready;
    m_ferr = 0;
    if (a && m_valid) void'(m_done_q.pop_front());
    if (acc) begin
      m_cur.push_back(d);
      m_mem[m_fill][m_cur.size()-1] = d;
      if (m_cur.size() == N) begin
        m_ferr = !l;
        m_done_q.push_back(m_fill);
        m_fill = (m_fill + 1) % NB;
        m_cur.delete();
      end else if (l) begin
        m_ferr = 1;
        m_cur.delete();
      end
    end
    m_ready = (m_done_q.size() < NB);
    m_valid = (m_done_q.size() > 0);
  endfunction

  function automatic logic [TW-1:0] pack_bank(input int b);
    logic [TW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = m_mem[b][k];
    return r;
  endfunction

  task automatic compare_model();
    chk("model_s_ready", s_ready, m_ready);
    chk("model_tensor_valid", tensor_valid, m_valid);
    chk("model_frame_err", frame_err, m_ferr);
    if (NB == 1) chk("model_tensor_out", tensor_out, pack_bank(0));
    else if (m_valid) chk("model_tensor_out", tensor_out, pack_bank(m_done_q[0]));
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit a);
    s_valid = v; s_data = d; s_last = l; tensor_ack = a;
    @(posedge clk);
    model_step(v, d, l, a);
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
    bit            l;
    bit            a;
    bit            er;
    bit            ev;
    bit            ef;
    bit            co;
    logic [63:0]   eo;
  } vec_t;
  vec_t vecs [$];

  function automatic void add(input bit v, input logic [DW-1:0] d, input bit l, input bit a,
                              input bit er, input bit ev, input bit ef, input bit co,
                              input logic [63:0] eo);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.a = a;
    r.er = er; r.ev = ev; r.ef = ef; r.co = co; r.eo = eo;
    vecs.push_back(r);
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t10, ta0, t40, t50, tmix;
    bit          seen_valid;
    t10  = 64'h1716151413121110;
    ta0  = 64'hA7A6A5A4A3A2A1A0;
    tmix = 64'hA7A6A5A4A3323130;
    t40  = 64'h4746454443424140;
    t50  = 64'h5756555453525150;

    add(0, 8'h00, 0, 0, 1, 0, 0, 1, 64'h0);
    for (int i = 0; i < 8; i++) add(1, 8'(8'h10 + i), i == 7, 0, i != 7, i == 7, 0, i == 7, t10);
    add(1, 8'hEE, 0, 0, 0, 1, 0, 1, t10);
    add(1, 8'hEE, 0, 1, 1, 0, 0, 1, t10);
    for (int i = 0; i < 8; i++) add(1, 8'(8'hA0 + i), i == 7, 0, i != 7, i == 7, 0, i == 7, ta0);
    add(0, 8'h00, 0, 1, 1, 0, 0, 0, 64'h0);
    for (int i = 0; i < 3; i++) add(1, 8'(8'h30 + i), i == 2, 0, 1, 0, i == 2, i == 2, tmix);
    add(0, 8'h00, 0, 0, 1, 0, 0, 1, tmix);
    for (int i = 0; i < 8; i++) add(1, 8'(8'h40 + i), i == 7, 0, i != 7, i == 7, 0, i == 7, t40);
    add(0, 8'h00, 0, 1, 1, 0, 0, 0, 64'h0);
    for (int i = 0; i < 8; i++) add(1, 8'(8'h50 + i), 0, 0, i != 7, i == 7, i == 7, i == 7, t50);
    add(0, 8'h00, 0, 1, 1, 0, 0, 1, t50);
    add(0, 8'h00, 0, 1, 1, 0, 0, 1, t50);

    model_reset();
    #1;
    chk("reset_s_ready", s_ready, 0);
    chk("reset_tensor_valid", tensor_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_tensor_out", tensor_out, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifndef TENSOR_LOADER_PINGPONG_EN
    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].a);
      chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].er);
      chk($sformatf("vec%0d_tensor_valid", i), tensor_valid, vecs[i].ev);
      chk($sformatf("vec%0d_frame_err", i), frame_err, vecs[i].ef);
      if (vecs[i].co) chk($sformatf("vec%0d_tensor_out", i), tensor_out, vecs[i].eo);
    end
`else
    cycle(0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 8'(8'hB0 + i), (i % 8) == 7, i == 15);
      chk($sformatf("b2b%0d_s_ready", i), s_ready, 1);
      if (i >= 7) chk($sformatf("b2b%0d_tensor_valid", i), tensor_valid, 1);
    end
    chk("b2b_second_tensor", tensor_out, 64'hBFBEBDBCBBBAB9B8);
    cycle(0, 8'h00, 0, 1);
    chk("b2b_drained_valid", tensor_valid, 0);
`endif

    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h60 + i), 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_tensor_valid", tensor_valid, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_tensor_out", tensor_out, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 8'h00, 0, 0);
    chk("release_s_ready", s_ready, 1);
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h70 + i), i == 7, 0);
    chk("after_rst_valid", tensor_valid, 1);
    chk("after_rst_tensor", tensor_out, 64'h7776757473727170);
    cycle(0, 8'h00, 0, 1);

    seen_valid = 0;
    for (int i = 0; i < 800; i++) begin
      bit v, l, a;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 2) == 0);
      cycle(v, 8'($urandom), l, a);
      if (tensor_valid) seen_valid = 1;
    end
    chk("random_some_tensor", seen_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
